// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM decode path.
// Latency: n/a (package only).
// Backpressure: n/a.
package pwm_pkg;

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } state_e;

  // Frame period in clk cycles for a given counter width.
  function automatic int unsigned period_of(input int unsigned cw);
    return 32'd1 << cw;
  endfunction

  // Map a measured high count to a signed code. A zero count is treated as
  // one so that a line held low reads as the most negative code.
  function automatic int decode_code(input int unsigned high, input int offset);
    int unsigned h;
    h = (high == 32'd0) ? 32'd1 : high;
    return int'(h) - 1 - offset;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// Latency: 2 clk cycles from d_i to q_o.
// Backpressure: none; free-running.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Metastability capture followed by a settling stage.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pwm_decoder.sv
// Recovers a signed sample from each PWM frame by counting high cycles.
// Latency: data_valid 3 edges after the first edge sampling pwm_in high.
// Backpressure: none; one strobe per frame boundary, no stall input.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int DATA_WIDTH    = 12,
  parameter int COUNTER_WIDTH = 10,
  parameter int OFFSET        = 512
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pwm_in,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         data_valid,
  output logic                         period_err,
  output logic                         stuck
);

  localparam int CW1 = COUNTER_WIDTH + 1;
  localparam logic [CW1-1:0] PERIOD = CW1'(period_of(COUNTER_WIDTH));

  logic                         s;
  logic                         s_d_q;
  logic                         rise;
  logic                         timeout;
  logic                         boundary;
  logic signed [CW1-1:0]        code;
  logic [CW1-1:0]               period_cnt_q, period_cnt_d;
  logic [CW1-1:0]               high_cnt_q, high_cnt_d;
  logic signed [DATA_WIDTH-1:0] data_q, data_d;
  logic                         valid_q, valid_d;
  logic                         perr_q, perr_d;
  logic                         stuck_q, stuck_d;
  state_e                       state_q, state_d;

  sync_2ff #(
    .RESET_VAL(1'b0)
  ) u_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (pwm_in),
    .q_o     (s)
  );

  // A rise wins over a simultaneous full-period count.
  assign rise     = s & ~s_d_q;
  assign timeout  = (period_cnt_q == PERIOD) && !rise;
  assign boundary = rise || timeout;
  assign code     = CW1'(decode_code(32'(high_cnt_q), OFFSET));

  // Counter update, acquisition/tracking FSM and output next-state.
  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    perr_d       = 1'b0;
    stuck_d      = stuck_q;
    if (boundary) begin
      period_cnt_d = CW1'(1);
      high_cnt_d   = CW1'(s);
      stuck_d      = timeout;
      state_d      = TRACK;
      // The first boundary after reset only aligns to the frame grid.
      if (state_q == TRACK) begin
        data_d  = DATA_WIDTH'(code);
        valid_d = 1'b1;
        perr_d  = rise && (period_cnt_q < PERIOD);
      end
    end else begin
      if (period_cnt_q < PERIOD) begin
        period_cnt_d = period_cnt_q + CW1'(1);
      end
      if (s && (high_cnt_q < PERIOD)) begin
        high_cnt_d = high_cnt_q + CW1'(1);
      end
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_d_q        <= 1'b0;
      state_q      <= ACQUIRE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      s_d_q        <= s;
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      perr_q       <= perr_d;
      stuck_q      <= stuck_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign period_err = perr_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: drives PWM waveforms and scores each strobe.
// Latency: n/a.
// Backpressure: n/a.
module tb_pwm_decoder;

  localparam int DW  = 12;
  localparam int CW  = 10;
  localparam int OFF = 512;
  localparam int PER = 1024;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 pwm_in = 1'b0;
  logic signed [DW-1:0] data_out;
  logic                 data_valid;
  logic                 period_err;
  logic                 stuck;

  int checks   = 0;
  int failures = 0;

  // Waveform for the current run: one entry per clk cycle.
  bit wv[$];

  pwm_decoder #(
    .DATA_WIDTH    (DW),
    .COUNTER_WIDTH (CW),
    .OFFSET        (OFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .period_err (period_err),
    .stuck      (stuck)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic add_frame(input int period, input int high);
    for (int i = 0; i < period; i++) wv.push_back(i < high);
  endtask

  // Generator frame for a given sample: high for ((d+OFF) mod PER)+1 cycles.
  task automatic add_gen(input int d);
    int h;
    h = (((d + OFF) % PER) + PER) % PER + 1;
    add_frame(PER, h);
  endtask

  // Line level as seen after synchronisation: two low cycles lead the waveform.
  function automatic int wpv(input int i);
    if (i < 2) return 0;
    return int'(wv[i-2]);
  endfunction

  // Reset for one cycle, play wv, compare strobes against the frame model.
  task automatic run(input string name);
    int ot[$], od[$], op[$], os[$];
    int et[$], ed[$], ep[$], es[$];
    int n, prev, j, hi, lim, last_stuck, last_code, nmin;
    bit armed, is_rise;

    n = wv.size();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk({name, ":rst_data"},  int'(data_out), 0);
    chk({name, ":rst_valid"}, int'(data_valid), 0);
    chk({name, ":rst_perr"},  int'(period_err), 0);
    chk({name, ":rst_stuck"}, int'(stuck), 0);
    reset = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (data_valid || period_err) begin
          ot.push_back(k - 1);
          od.push_back(int'(data_out));
          op.push_back(int'(period_err));
          os.push_back(int'(stuck));
        end
      end
      pwm_in = wv[k];
    end
    @(negedge clk);
    if (data_valid || period_err) begin
      ot.push_back(n - 1);
      od.push_back(int'(data_out));
      op.push_back(int'(period_err));
      os.push_back(int'(stuck));
    end

    // Frame model: a frame ends at the first rise within PER cycles of its
    // start, else exactly PER cycles later; its value is the high-cycle sum.
    prev = 0;
    armed = 1'b0;
    last_stuck = 0;
    last_code = 0;
    while (1) begin
      j = -1;
      is_rise = 1'b0;
      lim = prev + PER;
      if (lim > n - 1) lim = n - 1;
      for (int k = prev + 1; k <= lim; k++) begin
        if (wpv(k) == 1 && wpv(k - 1) == 0) begin
          j = k;
          is_rise = 1'b1;
          break;
        end
      end
      if (j < 0) begin
        if (prev + PER <= n - 1) j = prev + PER;
        else break;
      end
      hi = 0;
      for (int k = prev; k < j; k++) hi += wpv(k);
      if (armed) begin
        et.push_back(j);
        ed.push_back((hi < 1 ? 1 : hi) - 1 - OFF);
        ep.push_back(int'(is_rise && (j - prev) < PER));
        es.push_back(int'(!is_rise));
        last_code = (hi < 1 ? 1 : hi) - 1 - OFF;
      end
      armed = 1'b1;
      last_stuck = int'(!is_rise);
      prev = j;
    end

    chk({name, ":strobe_count"}, ot.size(), et.size());
    nmin = (ot.size() < et.size()) ? ot.size() : et.size();
    for (int i = 0; i < nmin; i++) begin
      chk($sformatf("%s:t%0d", name, i),     ot[i], et[i]);
      chk($sformatf("%s:data%0d", name, i),  od[i], ed[i]);
      chk($sformatf("%s:perr%0d", name, i),  op[i], ep[i]);
      chk($sformatf("%s:stuck%0d", name, i), os[i], es[i]);
    end
    chk({name, ":stuck_end"}, int'(stuck), last_stuck);
    chk({name, ":hold"}, int'(data_out), last_code);
    wv.delete();
  endtask

  initial begin
    bit tail[$];
    int p, h;

    // Nominal mid-scale loopback.
    repeat (4) add_gen(0);
    run("gen0");

    // Full duty: line never falls, frames end by timeout.
    repeat (4) add_gen(511);
    run("gen511");

    // Minimum duty: one high cycle per frame.
    repeat (4) add_gen(-512);
    run("genm512");

    // Line held low from reset.
    add_frame(3500, 0);
    run("low");

    // Short frame: rise 600 cycles after the previous one, 300 high.
    add_gen(0);
    add_frame(600, 300);
    add_gen(0);
    add_gen(0);
    run("short");

    // Reset lands in the low phase of a data_in=100 stream.
    repeat (5) add_gen(100);
    for (int i = 2848; i < wv.size(); i++) tail.push_back(wv[i]);
    while (wv.size() > 2848) void'(wv.pop_back());
    run("pre_rst");
    foreach (tail[i]) wv.push_back(tail[i]);
    run("mid_rst");

    // Random frame lengths, including overlong frames and frames with no fall.
    for (int r = 0; r < 3; r++) begin
      for (int f = 0; f < 8; f++) begin
        p = $urandom_range(1300, 2);
        h = $urandom_range(p, 1);
        add_frame(p, h);
      end
      run($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
